// File: rtl/keccak_sponge_ctrl.sv
// Absorb sequencer: packs 64-bit message lanes into rate blocks, applies pad10*1 with a domain byte, and hands each block to the permutation core.
// Latency: last accepted lane -> blk_valid is 1 cycle (full block) or 2 cycles (through PAD); core_done -> msg_done is 1 cycle.
// Backpressure: s_ready is high only while filling, so the lane stream stalls during issue and permutation; blk_data/blk_last are held until blk_ready.
module keccak_sponge_ctrl #(
    parameter int         WIDTH      = 64,
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DS         = 8'h06
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    input  logic [3:0]                 s_nbytes,
    output logic                       s_ready,
    output logic [0:4][0:4][WIDTH-1:0] blk_data,
    output logic                       blk_valid,
    output logic                       blk_last,
    input  logic                       blk_ready,
    input  logic                       core_done,
    output logic                       msg_done,
    output logic [15:0]                blk_cnt
);

    // Rate size in bytes and lane counter width (counter must reach RATE_LANES).
    localparam int RATE_B = 8 * RATE_LANES;
    localparam int CW     = $clog2(RATE_LANES + 1);

    localparam logic [CW-1:0]    TOP_IDX = CW'(RATE_LANES - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] DS_LANE = WIDTH'(DS);
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Rate portion of the block under construction; capacity lanes are never stored.
    logic [WIDTH-1:0] lanes   [RATE_LANES];
    // Same block with the tail of the final lane masked and padding applied.
    logic [WIDTH-1:0] padded  [RATE_LANES];
    // Pad-only block used when the message ends exactly on a rate boundary.
    logic [WIDTH-1:0] ovf_blk [RATE_LANES];

    logic [CW-1:0] lane_cnt;
    logic [3:0]    nb_q;      // valid bytes in the final lane, saturated to 8
    logic          last_q;    // block in flight is the final one
    logic          ovf_q;     // a pad-only block still has to follow

    // Position of the final lane and of the first pad byte, as plain integers.
    int  last_idx;
    int  nb_int;
    int  pad_pos;
    logic pad_fits;

    assign last_idx = int'(lane_cnt) - 1;
    assign nb_int   = int'(nb_q);
    assign pad_pos  = 8 * last_idx + nb_int;
    assign pad_fits = (pad_pos < RATE_B);

    // Byte-wise padding network: every byte decides independently whether it keeps
    // message data and whether it receives the domain byte and/or the closing 0x80.
    for (genvar i = 0; i < RATE_LANES; i++) begin : g_lane
        for (genvar k = 0; k < 8; k++) begin : g_byte
            localparam int BIDX = 8 * i + k;
            logic       keep;
            logic [7:0] ds_x;
            logic [7:0] end_x;
            assign keep  = (i < last_idx) || ((i == last_idx) && (k < nb_int));
            assign ds_x  = (pad_fits && (BIDX == pad_pos)) ? DS : 8'h00;
            assign end_x = (pad_fits && (BIDX == RATE_B - 1)) ? 8'h80 : 8'h00;
            assign padded[i][8*k +: 8] = (keep ? lanes[i][8*k +: 8] : 8'h00) ^ ds_x ^ end_x;
        end
        assign ovf_blk[i] = ((i == 0) ? DS_LANE : ZERO) |
                            ((i == RATE_LANES - 1) ? TOP_BIT : ZERO);
    end

    // Lane i sits at blk_data[i%5][i/5]; capacity lanes are tied to zero.
    for (genvar i = 0; i < 25; i++) begin : g_map
        if (i < RATE_LANES) begin : g_rate
            assign blk_data[i % 5][i / 5] = lanes[i];
        end else begin : g_cap
            assign blk_data[i % 5][i / 5] = ZERO;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        msg_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FILL;
            end
            ST_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        state_nxt = ST_PAD;
                    end else if (lane_cnt == TOP_IDX) begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_PAD: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                blk_valid = 1'b1;
                blk_last  = last_q;
                if (blk_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    if (ovf_q) begin
                        state_nxt = ST_ISSUE;
                    end else if (last_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                msg_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Block buffer, lane counter, flags and block counter, all driven by the current state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lanes    <= '{default: '0};
            lane_cnt <= '0;
            nb_q     <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            blk_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lanes    <= '{default: '0};
                    lane_cnt <= '0;
                    last_q   <= 1'b0;
                    ovf_q    <= 1'b0;
                    blk_cnt  <= '0;
                end
                ST_FILL: begin
                    if (s_valid) begin
                        lanes[lane_cnt] <= s_data;
                        lane_cnt        <= lane_cnt + CW'(1);
                        if (s_last) begin
                            nb_q <= (s_nbytes > 4'd8) ? 4'd8 : s_nbytes;
                        end
                    end
                end
                ST_PAD: begin
                    // A full final lane in the top rate slot leaves no room for padding:
                    // ship the data block as non-final and owe a pad-only block.
                    lanes  <= padded;
                    last_q <= pad_fits;
                    ovf_q  <= !pad_fits;
                end
                ST_ISSUE: begin
                    if (blk_ready) begin
                        blk_cnt <= blk_cnt + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        lane_cnt <= '0;
                        if (ovf_q) begin
                            lanes  <= ovf_blk;
                            ovf_q  <= 1'b0;
                            last_q <= 1'b1;
                        end else begin
                            lanes <= '{default: '0};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Bench for keccak_sponge_ctrl: randomized messages checked against a byte-level SHA-3 padding model.
// Latency of core_done -> msg_done and blk_valid hold under blk_ready=0 are checked directly.
// Inputs are driven and outputs sampled on the falling edge.
module tb_keccak_sponge_ctrl;

    localparam int         RL  = 17;
    localparam int         RB  = 8 * RL;
    localparam logic [7:0] DSB = 8'h06;

    logic                    clk = 1'b0;
    logic                    nrst = 1'b0;
    logic [63:0]             s_data = '0;
    logic                    s_valid = 1'b0;
    logic                    s_last = 1'b0;
    logic [3:0]              s_nbytes = '0;
    logic                    s_ready;
    logic [0:4][0:4][63:0]   blk_data;
    logic                    blk_valid;
    logic                    blk_last;
    logic                    blk_ready = 1'b0;
    logic                    core_done = 1'b0;
    logic                    msg_done;
    logic [15:0]             blk_cnt;

    always #5 clk = ~clk;

    keccak_sponge_ctrl #(.WIDTH(64), .RATE_LANES(RL), .DS(DSB)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_nbytes  (s_nbytes),
        .s_ready   (s_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready),
        .core_done (core_done),
        .msg_done  (msg_done),
        .blk_cnt   (blk_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0]  msg_q [$];   // message bytes
    logic [7:0]  pad_q [$];   // message after pad10*1, a whole number of rate blocks
    logic [63:0] lane_q [$];  // lane stream handed to the DUT
    logic [3:0]  nb_last;
    logic [63:0] cap [25];    // lanes of the most recent block seen on blk_data

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_lane(input int i);
        logic [1599:0] flat;
        logic [1599:0] t;
        int x;
        int y;
        flat = blk_data;
        x = i % 5;
        y = i / 5;
        t = flat >> (((4 - x) * 5 + (4 - y)) * 64);
        return t[63:0];
    endfunction

    // Expected lane i of block j, read straight out of the padded byte string.
    function automatic logic [63:0] exp_lane(input int j, input int i);
        logic [63:0] v;
        v = '0;
        if (i < RL) begin
            for (int k = 0; k < 8; k++) begin
                v = v | (64'(pad_q[j * RB + 8 * i + k]) << (8 * k));
            end
        end
        return v;
    endfunction

    // Build the padded reference and the lane stream for msg_q. Bytes past the
    // message end are random so masking is exercised; extra=1 ends an 8-aligned
    // message with an additional empty lane.
    task automatic prep(input bit extra);
        int L;
        int nl;
        logic [63:0] v;
        pad_q = msg_q;
        pad_q.push_back(DSB);
        while (pad_q.size() % RB != 0) pad_q.push_back(8'h00);
        pad_q[pad_q.size() - 1] = pad_q[pad_q.size() - 1] ^ 8'h80;
        L  = msg_q.size();
        nl = (L == 0) ? 1 : (L + 7) / 8;
        lane_q.delete();
        for (int t = 0; t < nl; t++) begin
            v = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                if (8 * t + k < L) begin
                    v = (v & ~(64'hFF << (8 * k))) | (64'(msg_q[8 * t + k]) << (8 * k));
                end
            end
            lane_q.push_back(v);
        end
        nb_last = 4'(L - 8 * (nl - 1));
        if (extra && L > 0 && (L % 8) == 0) begin
            lane_q.push_back({$urandom, $urandom});
            nb_last = 4'd0;
        end
    endtask

    task automatic rand_msg(input int L);
        msg_q.delete();
        for (int b = 0; b < L; b++) msg_q.push_back(8'($urandom));
    endtask

    // Drive one message and act as the core. stall=1 holds off the first block for
    // 10 cycles with a stray core_done; abort_at>=0 returns once that many lanes went in.
    task automatic run_msg(input bit stall, input int abort_at);
        int  li;
        int  bi;
        int  cd;
        int  budget;
        int  stall_left;
        int  nblk;
        bit  cd_on;
        bit  seen;
        bit  exp_done;
        li = 0; bi = 0; cd = 0; budget = 4000;
        stall_left = stall ? 10 : 0;
        nblk = pad_q.size() / RB;
        cd_on = 0; seen = 0; exp_done = 0;
        forever begin
            @(negedge clk);
            if (exp_done) begin
                core_done = 1'b0;
                chk("msg_done_latency", msg_done, 1'b1);
                chk("blk_cnt_final", blk_cnt, 64'(nblk));
                chk("lanes_consumed", 64'(li), 64'(lane_q.size()));
                @(negedge clk);
                chk("msg_done_width", msg_done, 1'b0);
                return;
            end
            core_done = 1'b0;
            blk_ready = 1'b0;
            s_valid   = 1'b0;
            s_last    = 1'b0;
            s_nbytes  = 4'($urandom_range(0, 8));
            s_data    = {$urandom, $urandom};
            if (msg_done) chk("msg_done_early", msg_done, 1'b0);
            if (abort_at >= 0 && li == abort_at) return;
            budget--;
            if (budget == 0) begin
                chk("timeout_msg_done", msg_done, 1'b1);
                return;
            end
            if (cd_on) begin
                if (cd == 0) begin
                    core_done = 1'b1;
                    cd_on = 0;
                    if (bi == nblk) exp_done = 1;
                end else begin
                    cd--;
                end
            end
            if (blk_valid && !seen) begin
                seen = 1;
                for (int i = 0; i < 25; i++) begin
                    cap[i] = dut_lane(i);
                    chk($sformatf("blk%0d_lane%0d", bi, i), cap[i], exp_lane(bi, i));
                end
                chk("blk_last", blk_last, (bi == nblk - 1) ? 1'b1 : 1'b0);
                chk("blk_cnt_at_issue", blk_cnt, 64'(bi));
                chk("s_ready_in_issue", s_ready, 1'b0);
            end
            if (seen && stall_left > 0) begin
                chk("stall_blk_valid", blk_valid, 1'b1);
                chk("stall_lane0", dut_lane(0), exp_lane(bi, 0));
                chk("stall_lane16", dut_lane(16), exp_lane(bi, 16));
                chk("stall_s_ready", s_ready, 1'b0);
                chk("stall_blk_cnt", blk_cnt, 64'(bi));
                if (stall_left == 6) core_done = 1'b1;
                stall_left--;
            end else if (seen) begin
                blk_ready = ($urandom_range(0, 2) != 0);
                if (blk_ready) begin
                    bi++;
                    seen  = 0;
                    cd    = $urandom_range(0, 3);
                    cd_on = 1;
                end
            end
            if (s_ready && li < lane_q.size() && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = lane_q[li];
                s_last  = (li == lane_q.size() - 1);
                if (s_last) s_nbytes = nb_last;
                li++;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b0);
        chk({tag, "_blk_valid"}, blk_valid, 1'b0);
        chk({tag, "_blk_last"}, blk_last, 1'b0);
        chk({tag, "_msg_done"}, msg_done, 1'b0);
        chk({tag, "_blk_cnt"}, blk_cnt, 64'd0);
        chk({tag, "_blk_data"}, 64'(|blk_data), 64'd0);
    endtask

    int lens [12] = '{7, 8, 9, 64, 134, 137, 200, 271, 272, 273, 300, 408};

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        nrst = 1'b1;
        @(negedge clk);
        chk("fill_after_idle", s_ready, 1'b1);

        // Empty message.
        msg_q.delete();
        prep(0);
        run_msg(0, -1);
        chk("empty_lane0", cap[0], 64'h0000_0000_0000_0006);
        chk("empty_lane16", cap[16], 64'h8000_0000_0000_0000);

        // "abc".
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        prep(0);
        run_msg(0, -1);
        chk("abc_lane0", cap[0], 64'h0000_0000_0663_6261);
        chk("abc_lane16", cap[16], 64'h8000_0000_0000_0000);

        // 135 bytes: DS and 0x80 share the last rate byte.
        rand_msg(135);
        prep(0);
        run_msg(0, -1);
        chk("b135_top_byte", 64'(cap[16][63:56]), 64'h86);

        // 136 bytes: overflow into a pad-only block.
        rand_msg(136);
        prep(0);
        run_msg(0, -1);
        chk("b136_pad_lane0", cap[0], 64'h0000_0000_0000_0006);
        chk("b136_pad_lane16", cap[16], 64'h8000_0000_0000_0000);

        // Block held under blk_ready=0 with a stray core_done.
        rand_msg(20);
        prep(0);
        run_msg(1, -1);

        // Randomized lengths, including rate-boundary neighbours.
        for (int n = 0; n < 12; n++) begin
            rand_msg(lens[n]);
            prep($urandom_range(0, 1) == 1);
            run_msg(0, -1);
        end
        for (int n = 0; n < 6; n++) begin
            rand_msg($urandom_range(0, 420));
            prep($urandom_range(0, 1) == 1);
            run_msg(0, -1);
        end

        // Reset while filling lane 5 of the second block.
        rand_msg(300);
        prep(0);
        run_msg(0, 22);
        chk("pre_reset_blk_cnt", blk_cnt, 64'd1);
        chk("pre_reset_s_ready", s_ready, 1'b1);
        nrst = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge clk);
        nrst = 1'b1;
        rand_msg(50);
        prep(0);
        run_msg(0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
